alu_pipelined: RTL and testbench
================================

// Module: alu_pipelined
// PURPOSE
//  Parametrised, pipelined integer execute unit; successor to single-entry ADD-only ALU.
//  Accepts uops from decode over D__XIntf (X side); returns results to writeback over X__WIntf (X side).
//  Full RV32I integer ALU op set; p_num_stages-deep elastic pipeline with backpressure.
//  Throughput 1 uop/cycle when W.rdy held high.
// PARAMETERS
//  p_addr_bits     32  width of pc
//  p_data_bits     32  width of operands/result (power of 2, >=8)
//  p_seq_num_bits  5   width of sequence number
//  p_num_stages    2   pipeline register stages (>=1); min latency D_xfer -> W.val
// PORTS
//  clk         in   1               clock; all state updates on posedge
//  rst         in   1               reset; synchronous, active-high
//  D.val       in   1               decode presents uop
//  D.rdy       out  1               unit can accept uop this cycle
//  D.pc        in   p_addr_bits     uop pc
//  D.seq_num   in   p_seq_num_bits  uop sequence number
//  D.op1/op2   in   p_data_bits     source operands
//  D.waddr     in   5               destination register
//  D.uop       in   rv_uop          operation
//  W.val       out  1               result valid
//  W.rdy       in   1               writeback accepts result
//  W.pc/seq_num/waddr  out          carried unchanged from D
//  W.wdata     out  p_data_bits     result
//  W.wen       out  1               write enable
// BEHAVIOUR
//  Stages S[0..N-1], N=p_num_stages; each holds val,pc,seq_num,waddr,uop-derived result,wen.
//  Result computed combinationally from D fields and captured into S[0] on D_xfer (D.val&D.rdy).
//  Ops (sh = op2[$clog2(p_data_bits)-1:0]):
//   OP_ADD op1+op2; OP_SUB op1-op2 (mod 2^p_data_bits)
//   OP_AND/OP_OR/OP_XOR bitwise; OP_SLL op1<<sh; OP_SRL logical >>sh; OP_SRA arith >>>sh
//   OP_SLT signed op1<op2 ? 1:0; OP_SLTU unsigned compare; OP_LUI result=op2
//   any other uop: wdata=0, wen=0 (still flows, still presented to W; never X)
//  Advance: adv[N-1] = ~S[N-1].val | W.rdy; adv[i] = ~S[i].val | adv[i+1].
//   When adv[i]: S[i+1] <= S[i] (S[i].val propagates; empty bubble propagates val=0).
//   When ~adv[i]: S[i] holds.
//  D.rdy = adv[0] (combinational from W.rdy through valid chain); W.val = S[N-1].val.
//  W.* driven from S[N-1]; payload don't-care (hold last) when W.val=0.
//  Latency: exactly N cycles D_xfer -> W.val with no backpressure; bubbles collapse under stall.
//  Full: all N stages valid and W.rdy=0 -> D.rdy=0; no uop dropped or duplicated.
//  Simultaneous D_xfer and W_xfer with pipeline full: both occur, occupancy unchanged.
//  In-order: W seq_num order equals D acceptance order; no reordering.
//  Reset: all S[i].val=0 -> W.val=0, D.rdy=1 cycle after rst; payload regs not reset.
//  Reset mid-operation: all in-flight uops discarded; no W.val in cycle after rst.
//  W.val never depends on W.rdy (no comb loop); D.rdy may depend on W.rdy.
// TESTING
//  N=2, W.rdy=1, ADD op1=5 op2=7 seq=3 waddr=4 -> W.val 2 cycles later, wdata=12 wen=1 seq=3 waddr=4.
//  Back-to-back SUB 0-1, SRA 0x80000000>>4, SLT -1<1, SLTU 0xFFFFFFFF<1 each cycle
//   -> wdata 0xFFFFFFFF, 0xF8000000, 1, 0 on consecutive cycles.
//  W.rdy=0 for 6 cycles, D.val=1 -> exactly N uops accepted, D.rdy=0 after; release -> all drain in order.
//  Full pipe, W.rdy=1 and D.val=1 same cycle -> one accept + one retire, occupancy stays N.
//  Unsupported uop -> W.val with wen=0, wdata=0; SLL op2=0x21 uses sh=1 (0x1<<1 = 2).
//  rst asserted with 2 uops in flight -> W.val=0 next cycle, D.rdy=1, neither uop appears.

Source files
------------

// File: rtl/alu_pipelined.sv
// alu_pipelined: elastic, p_num_stages-deep RV32I integer execute unit.
//
// The result is computed combinationally from the decode fields. It is
// captured into stage 0 when a uop is accepted (d_val & d_rdy). Stages move
// forward whenever the stage ahead can make room. Bubbles collapse under a
// stall, so the unit accepts as many uops as it has stages before it applies
// backpressure.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (clears stage valids only)
//   d_val, d_rdy    decode handshake (d_rdy depends combinationally on w_rdy)
//   d_pc, d_seq_num, d_waddr, d_op1, d_op2, d_uop   uop fields from decode
//   w_val, w_rdy    writeback handshake (w_val is purely registered)
//   w_pc, w_seq_num, w_waddr   carried unchanged from decode
//   w_wdata, w_wen  result and write enable
//
// uop encoding (d_uop, 4 bits):
//   0 ADD  1 SUB  2 AND  3 OR  4 XOR  5 SLL  6 SRL  7 SRA  8 SLT  9 SLTU  10 LUI
//   Any other code yields wdata=0 and wen=0. The uop still flows to writeback.

module alu_pipelined #(
  parameter int unsigned p_addr_bits    = 32,
  parameter int unsigned p_data_bits    = 32,
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_num_stages   = 2
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      d_val,
  output logic                      d_rdy,
  input  logic [p_addr_bits-1:0]    d_pc,
  input  logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic [p_data_bits-1:0]    d_op1,
  input  logic [p_data_bits-1:0]    d_op2,
  input  logic [4:0]                d_waddr,
  input  logic [3:0]                d_uop,

  output logic                      w_val,
  input  logic                      w_rdy,
  output logic [p_addr_bits-1:0]    w_pc,
  output logic [p_seq_num_bits-1:0] w_seq_num,
  output logic [4:0]                w_waddr,
  output logic [p_data_bits-1:0]    w_wdata,
  output logic                      w_wen
);

  localparam int unsigned sh_bits = $clog2(p_data_bits);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  // ---------------------------------------------------------------------------
  // Combinational ALU on the decode-side fields
  // ---------------------------------------------------------------------------
  logic [sh_bits-1:0]     sh;
  logic [p_data_bits-1:0] alu_wdata;
  logic                   alu_wen;

  assign sh = d_op2[sh_bits-1:0];

  always_comb begin
    alu_wdata = '0;
    alu_wen   = 1'b1;
    case (d_uop)
      OP_ADD:  alu_wdata = d_op1 + d_op2;
      OP_SUB:  alu_wdata = d_op1 - d_op2;
      OP_AND:  alu_wdata = d_op1 & d_op2;
      OP_OR:   alu_wdata = d_op1 | d_op2;
      OP_XOR:  alu_wdata = d_op1 ^ d_op2;
      OP_SLL:  alu_wdata = d_op1 << sh;
      OP_SRL:  alu_wdata = d_op1 >> sh;
      OP_SRA:  alu_wdata = $unsigned($signed(d_op1) >>> sh);
      OP_SLT:  alu_wdata[0] = $signed(d_op1) < $signed(d_op2);
      OP_SLTU: alu_wdata[0] = d_op1 < d_op2;
      OP_LUI:  alu_wdata = d_op2;
      default: begin
        alu_wdata = '0;
        alu_wen   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  logic [p_num_stages-1:0]   val_q;
  logic [p_num_stages-1:0]   adv;
  logic [p_addr_bits-1:0]    pc_q    [p_num_stages];
  logic [p_seq_num_bits-1:0] seq_q   [p_num_stages];
  logic [4:0]                waddr_q [p_num_stages];
  logic [p_data_bits-1:0]    wdata_q [p_num_stages];
  logic                      wen_q   [p_num_stages];

  // Stage i may load when some stage at or beyond it is empty, or the tail
  // retires. This is the unrolled form of adv[i] = ~val[i] | adv[i+1].
  for (genvar i = 0; i < p_num_stages; i++) begin : g_adv
    assign adv[i] = w_rdy | ~(&val_q[p_num_stages-1:i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      if (adv[0]) val_q[0] <= d_val;
      for (int i = 1; i < int'(p_num_stages); i++) begin
        if (adv[i]) val_q[i] <= val_q[i-1];
      end
    end
  end

  // Payload loads only with a valid uop. A bubble therefore leaves the last
  // payload in place instead of overwriting it.
  always_ff @(posedge clk) begin
    if (adv[0] && d_val) begin
      pc_q[0]    <= d_pc;
      seq_q[0]   <= d_seq_num;
      waddr_q[0] <= d_waddr;
      wdata_q[0] <= alu_wdata;
      wen_q[0]   <= alu_wen;
    end
    for (int i = 1; i < int'(p_num_stages); i++) begin
      if (adv[i] && val_q[i-1]) begin
        pc_q[i]    <= pc_q[i-1];
        seq_q[i]   <= seq_q[i-1];
        waddr_q[i] <= waddr_q[i-1];
        wdata_q[i] <= wdata_q[i-1];
        wen_q[i]   <= wen_q[i-1];
      end
    end
  end

  assign d_rdy     = adv[0];
  assign w_val     = val_q[p_num_stages-1];
  assign w_pc      = pc_q[p_num_stages-1];
  assign w_seq_num = seq_q[p_num_stages-1];
  assign w_waddr   = waddr_q[p_num_stages-1];
  assign w_wdata   = wdata_q[p_num_stages-1];
  assign w_wen     = wen_q[p_num_stages-1];

endmodule

// File: tb/tb_alu_pipelined.sv
module tb_alu_pipelined;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_BAD  = 4'd15;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_val;
  logic        d_rdy;
  logic [31:0] d_pc;
  logic [4:0]  d_seq_num;
  logic [31:0] d_op1;
  logic [31:0] d_op2;
  logic [4:0]  d_waddr;
  logic [3:0]  d_uop;
  logic        w_val;
  logic        w_rdy;
  logic [31:0] w_pc;
  logic [4:0]  w_seq_num;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_wen;

  alu_pipelined #(
    .p_addr_bits   (32),
    .p_data_bits   (32),
    .p_seq_num_bits(5),
    .p_num_stages  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_val    (d_val),
    .d_rdy    (d_rdy),
    .d_pc     (d_pc),
    .d_seq_num(d_seq_num),
    .d_op1    (d_op1),
    .d_op2    (d_op2),
    .d_waddr  (d_waddr),
    .d_uop    (d_uop),
    .w_val    (w_val),
    .w_rdy    (w_rdy),
    .w_pc     (w_pc),
    .w_seq_num(w_seq_num),
    .w_waddr  (w_waddr),
    .w_wdata  (w_wdata),
    .w_wen    (w_wen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    int          t_in;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          chk = 0;
  int          err = 0;
  int          cyc = 0;
  logic [31:0] e_wdata;
  logic        e_wen;
  int          e_lat;
  int          s;
  int          sz;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the W handshake, record the D handshake, advance.
  task automatic step();
    exp_t e;
    #1;
    if (!rst && w_val && w_rdy) begin
      if (sb.size() == 0) begin
        check("spurious_w_val", 128'(w_val), 128'd0);
      end else begin
        e = sb.pop_front();
        check("w_payload", 128'({w_seq_num, w_waddr, w_pc, w_wdata, w_wen}),
              128'({e.seq, e.waddr, e.pc, e.wdata, e.wen}));
        if (e.lat != 0) check("latency", 128'(cyc - e.t_in), 128'(e.lat));
      end
    end
    if (!rst && d_val && d_rdy) begin
      e.pc    = d_pc;
      e.seq   = d_seq_num;
      e.waddr = d_waddr;
      e.wdata = e_wdata;
      e.wen   = e_wen;
      e.t_in  = cyc;
      e.lat   = e_lat;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic [3:0] uop, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] seq, input logic [4:0] waddr,
                       input logic [31:0] exp_wdata, input logic exp_wen, input int lat);
    d_val     = 1'b1;
    d_uop     = uop;
    d_op1     = a;
    d_op2     = b;
    d_seq_num = seq;
    d_waddr   = waddr;
    d_pc      = 32'h1000 + {25'd0, seq, 2'b00};
    e_wdata   = exp_wdata;
    e_wen     = exp_wen;
    e_lat     = lat;
  endtask

  task automatic send(input logic [3:0] uop, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] seq, input logic [4:0] waddr,
                      input logic [31:0] exp_wdata, input logic exp_wen, input int lat);
    drive(uop, a, b, seq, waddr, exp_wdata, exp_wen, lat);
    step();
  endtask

  task automatic drain();
    d_val = 1'b0;
    w_rdy = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    step();
    check("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_val = 1'b0;
    w_rdy = 1'b1;
    drive(OP_ADD, 0, 0, 0, 0, 0, 1'b1, 0);
    d_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_w_val", 128'(w_val), 128'd0);
    check("reset_d_rdy", 128'(d_rdy), 128'd1);
    rst = 1'b0;
    step();

    // Single ADD, two-cycle latency
    send(OP_ADD, 5, 7, 5'd3, 5'd4, 32'd12, 1'b1, 2);
    drain();

    // Back-to-back sign-sensitive ops
    send(OP_SUB,  32'd0,          32'd1, 5'd4, 5'd1, 32'hFFFF_FFFF, 1'b1, 2);
    send(OP_SRA,  32'h8000_0000,  32'd4, 5'd5, 5'd2, 32'hF800_0000, 1'b1, 2);
    send(OP_SLT,  32'hFFFF_FFFF,  32'd1, 5'd6, 5'd3, 32'd1,         1'b1, 2);
    send(OP_SLTU, 32'hFFFF_FFFF,  32'd1, 5'd7, 5'd4, 32'd0,         1'b1, 2);
    drain();

    // Remaining ops, unsupported uop, shift-amount truncation
    send(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd8,  5'd5,  32'h00F0_000F, 1'b1, 2);
    send(OP_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd9,  5'd6,  32'hFFF0_0FFF, 1'b1, 2);
    send(OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd10, 5'd7,  32'hFF00_0FF0, 1'b1, 2);
    send(OP_SRL, 32'h8000_0000, 32'd4,         5'd11, 5'd8,  32'h0800_0000, 1'b1, 2);
    send(OP_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 5'd12, 5'd9,  32'h1234_5000, 1'b1, 2);
    send(OP_SLL, 32'd1,         32'h21,        5'd13, 5'd10, 32'd2,         1'b1, 2);
    send(OP_BAD, 32'd3,         32'd4,         5'd14, 5'd11, 32'd0,         1'b0, 2);
    send(OP_SUB, 32'd3,         32'd5,         5'd15, 5'd12, 32'hFFFF_FFFE, 1'b1, 2);
    send(OP_ADD, 32'hFFFF_FFFF, 32'd2,         5'd16, 5'd13, 32'd1,         1'b1, 2);
    drain();

    // Six cycles of backpressure: exactly two accepted, then in-order drain
    w_rdy = 1'b0;
    s = 20;
    for (int k = 0; k < 6; k++) begin
      drive(OP_ADD, 32'(s), 32'd100, 5'(s), 5'(s - 10), 32'(s + 100), 1'b1, 0);
      sz = sb.size();
      step();
      if (sb.size() > sz) s++;
    end
    check("stall_accepted", 128'(s - 20), 128'd2);
    #1;
    check("stall_d_rdy", 128'(d_rdy), 128'd0);
    check("stall_w_val", 128'(w_val), 128'd1);
    drain();

    // Full pipe: retire and accept in the same cycle keeps occupancy at two
    w_rdy = 1'b0;
    send(OP_ADD, 32'd1, 32'd1, 5'd24, 5'd1, 32'd2, 1'b1, 0);
    send(OP_ADD, 32'd2, 32'd2, 5'd25, 5'd2, 32'd4, 1'b1, 0);
    w_rdy = 1'b1;
    drive(OP_ADD, 32'd3, 32'd3, 5'd26, 5'd3, 32'd6, 1'b1, 0);
    #1;
    check("full_xfer_d_rdy", 128'(d_rdy), 128'd1);
    step();
    w_rdy = 1'b0;
    drive(OP_ADD, 32'd4, 32'd4, 5'd27, 5'd4, 32'd8, 1'b1, 0);
    #1;
    check("full_again_d_rdy", 128'(d_rdy), 128'd0);
    check("full_occupancy", 128'(sb.size()), 128'd2);
    check("full_w_val", 128'(w_val), 128'd1);
    drain();

    // Reset with two uops in flight discards both
    send(OP_ADD, 32'd9, 32'd9, 5'd28, 5'd5, 32'd18, 1'b1, 0);
    send(OP_ADD, 32'd8, 32'd8, 5'd29, 5'd6, 32'd16, 1'b1, 0);
    d_val = 1'b0;
    w_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("midrst_w_val", 128'(w_val), 128'd0);
    check("midrst_d_rdy", 128'(d_rdy), 128'd1);
    rst = 1'b0;
    sb.delete();
    w_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_quiet", 128'(w_val), 128'd0);
      step();
    end
    send(OP_ADD, 32'd40, 32'd2, 5'd30, 5'd7, 32'd42, 1'b1, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
